// File: rtl/calc_result_buffer.sv
// calc_result_buffer: change-detecting capture FIFO behind the calculator.
// Optional drop statistics: define CALC_RESULT_BUF_STATS_EN for drop_count.
module calc_result_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [1:0]                 operation,
    input  logic [DATA_W-1:0]          calc_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [1:0]                 res_op,
    output logic [DATA_W-1:0]          res_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clear_overflow,
    output logic [15:0]                drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_W + 2;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [EW-1:0]     head;

    logic [DATA_W-1:0] last_val;
    logic [1:0]        last_op;
    logic              primed;

    logic              cap_event;
    logic              fifo_full;
    logic              fifo_empty;
    logic              do_pop;
    logic              do_push;
    logic              do_drop;

    // A new result is anything that differs from the last captured pair,
    // or the very first sample after reset.
    always_comb begin
        cap_event = 1'b0;
        if (enable) begin
            cap_event = ~primed
                      | (calc_out != last_val)
                      | (operation != last_op);
        end
    end

    // Push/pop/drop qualification; a full FIFO still accepts a push
    // when the head leaves in the same cycle.
    always_comb begin
        fifo_full  = (level == FULL_LVL);
        fifo_empty = (level == '0);
        do_pop     = ~fifo_empty & res_ready;
        do_push    = cap_event & (~fifo_full | do_pop);
        do_drop    = cap_event & fifo_full & ~do_pop;
    end

    // Detector state follows every event, even ones that end up dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed   <= 1'b0;
            last_val <= '0;
            last_op  <= '0;
        end else if (cap_event) begin
            primed   <= 1'b1;
            last_val <= calc_out;
            last_op  <= operation;
        end
    end

    // Storage is written on push only and carries no reset.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= {operation, calc_out};
        end
    end

    // Write pointer wraps naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
        end else if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every accepted handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks writes minus reads; simultaneous push+pop holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow; a drop in the clearing cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (clear_overflow) begin
            overflow <= do_drop;
        end else if (do_drop) begin
            overflow <= 1'b1;
        end
    end

`ifdef CALC_RESULT_BUF_STATS_EN
    // Saturating drop counter, restarted by clear_overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (clear_overflow) begin
            drop_count <= do_drop ? 16'd1 : 16'd0;
        end else if (do_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

    // First-word-fall-through head, forced to zero while empty.
    always_comb begin
        head      = mem[rd_ptr];
        res_valid = ~fifo_empty;
        res_op    = '0;
        res_data  = '0;
        if (!fifo_empty) begin
            res_op   = head[EW-1:DATA_W];
            res_data = head[DATA_W-1:0];
        end
    end

endmodule
